mem_port_arbiter: RTL

Sequences a single-ported, fixed-latency unified memory shared between the instruction-fetch (IF) and data-memory (MEM) stages of the five-stage pipeline. It arbitrates the two requesters, issues one memory command per transaction and returns read data with a one-cycle valid pulse. It drives per-stage stall signals that the pipeline control combines with the load-use stall.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_lat_cnt.sv | 29 ++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM unified-memory port arbiter.
// Holds the FSM state enum, grant-source enum and legal memory-latency range.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_t;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 7;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Latency counter: cleared while clr, counts up while en, done at MEM_LAT-1.
// Done is combinational from the count register; no backpressure.
module mem_arb_lat_cnt #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic arst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == CNT_W'(MEM_LAT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM stages onto one fixed-latency memory: command issued in the grant cycle,
// valid pulses MEM_LAT cycles later; stalls track req & ~valid. MEM_ARB_RR_EN selects round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_valid,
  output logic                  if_stall,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [DATA_W/8-1:0]   dm_be,
  input  logic [ADDR_W-1:0]     dm_addr,
  input  logic [DATA_W-1:0]     dm_wdata,
  output logic [DATA_W-1:0]     dm_rdata,
  output logic                  dm_valid,
  output logic                  dm_stall,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_lat_chk
    $error("mem_port_arbiter: MEM_LAT must be within 1..7");
  end

  state_t state, state_nxt;
  gnt_t   gnt;
  logic   cnt_done;

`ifdef MEM_ARB_RR_EN
  // rr_ptr == 0 favours IF on the next contended grant
  logic rr_ptr;

  always_comb begin
    if (if_req && dm_req) begin
      gnt = rr_ptr ? GNT_DM : GNT_IF;
    end else begin
      gnt = dm_req ? GNT_DM : GNT_IF;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rr_ptr <= 1'b0;
    end else if (state == IDLE && if_req && dm_req) begin
      rr_ptr <= (gnt == GNT_IF);
    end
  end
`else
  always_comb begin
    gnt = dm_req ? GNT_DM : GNT_IF;
  end
`endif

  mem_arb_lat_cnt #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .clr    (state == IDLE),
    .en     (state != IDLE),
    .done   (cnt_done)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_valid  = 1'b0;
    dm_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          mem_en = 1'b1;
          if (gnt == GNT_DM) begin
            mem_we    = dm_we;
            mem_be    = dm_be;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            state_nxt = BUSY_DM;
          end else begin
            // fetches always read the full word
            mem_be    = '1;
            mem_addr  = if_addr;
            state_nxt = BUSY_IF;
          end
        end
      end
      BUSY_IF: begin
        if (cnt_done) begin
          if_valid  = if_req;
          state_nxt = IDLE;
        end
      end
      BUSY_DM: begin
        if (cnt_done) begin
          dm_valid  = dm_req;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign if_rdata = mem_rdata;
  assign dm_rdata = mem_rdata;
  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_valid;

endmodule
